// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Drives one shared decoder with each digit's code in turn, with a blanked guard before each enable.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int BLANK      = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] din,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              dig_code,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    PH_GUARD,
    PH_ON
  } phase_e;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  logic [DW-1:0]         active_q, active_d;
  logic                  pending_q, pending_d;
  logic [3:0]            dig_code_q, dig_code_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic                  frame_tick_q, frame_tick_d;
  phase_e                phase_d;
  logic [3:0]            codes [NUM_DIGITS];

  // Slot counter and digit index for the upcoming cycle.
  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Double buffer: a load coinciding with the frame boundary bypasses the shadow stage.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (load) begin
      shadow_d = din;
      if (frame_tick_q) begin
        active_d  = din;
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
      end
    end else if (frame_tick_q && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      codes[i] = active_d[4*i +: 4];
    end
  end

  // Outputs are decoded from next-state so the registered values line up with cnt/idx.
  always_comb begin
    phase_d    = (cnt_d < CNT_BLANK) ? PH_GUARD : PH_ON;
    dig_code_d = codes[idx_d];
    dig_en_d   = '1;
    if (phase_d == PH_ON && !blank_mask[idx_d]) begin
      dig_en_d[idx_d] = 1'b0;
    end
    frame_tick_d = (idx_d == IDX_LAST) && (cnt_d == CNT_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  // NOTE: the data buffers are plain registers, so they are cleared by reset along with the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      pending_q    <= 1'b0;
      dig_code_q   <= '0;
      dig_en_q     <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      dig_code_q   <= dig_code_d;
      dig_en_q     <= dig_en_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign dig_code   = dig_code_q;
  assign dig_en     = dig_en_q;
  assign frame_tick = frame_tick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: checkpoint table, directed corner sequences,
// and random stimulus compared against a cycle-number based display model.
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [15:0]   din = '0;
  logic [3:0]    blank_mask = '0;
  logic [3:0]    dig_code;
  logic [3:0]    dig_en;
  logic          frame_tick;
  logic          pending;

  seg_scan_ctrl #(
    .NUM_DIGITS(N),
    .DIV       (DIV),
    .BLANK     (BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (din),
    .blank_mask(blank_mask),
    .dig_code  (dig_code),
    .dig_en    (dig_en),
    .frame_tick(frame_tick),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          t        = 0;
  logic [15:0] m_active, m_shadow;
  logic        m_pending;
  logic [3:0]  mask_prev;

  typedef struct {
    int          cyc;
    logic        ld;
    logic [15:0] d;
    logic [3:0]  code;
    logic [3:0]  en;
    logic        tick;
    logic        pend;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  // Model view of cycle t: slot/position follow directly from the cycle number.
  task automatic check_model();
    int         slot, pos;
    logic [3:0] e_en;
    slot = (t / DIV) % N;
    pos  = t % DIV;
    e_en = 4'hF;
    if (pos >= BLANK && !mask_prev[slot]) e_en[slot] = 1'b0;
    check("model dig_code", dig_code, m_active[4*slot +: 4]);
    check("model dig_en", dig_en, e_en);
    check("model frame_tick", frame_tick, (slot == N-1 && pos == DIV-1));
    check("model pending", pending, m_pending);
  endtask

  // One cycle: check outputs of cycle t, drive its inputs, advance the model at the edge.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] m);
    logic is_frame_end;
    check_model();
    load = ld;
    din = d;
    blank_mask = m;
    is_frame_end = (t % FRAME == FRAME - 1);
    @(posedge clk);
    if (ld) begin
      m_shadow = d;
      if (is_frame_end) begin
        m_active  = d;
        m_pending = 1'b0;
      end else begin
        m_pending = 1'b1;
      end
    end else if (is_frame_end && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    mask_prev = m;
    t++;
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    load = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    m_active = '0;
    m_shadow = '0;
    m_pending = 1'b0;
    mask_prev = blank_mask;
    check("reset dig_en", dig_en, 4'hF);
    check("reset dig_code", dig_code, 4'h0);
    check("reset frame_tick", frame_tick, 1'b0);
    check("reset pending", pending, 1'b0);
  endtask

  initial begin
    logic        ld;
    logic [15:0] d;
    logic [3:0]  m;
    logic        saw_one;

    tbl[0]  = '{0,  1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b0};
    tbl[2]  = '{2,  1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b0};
    tbl[3]  = '{5,  1'b1, 16'h4321, 4'h0, 4'hE, 1'b0, 1'b0};
    tbl[4]  = '{6,  1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b1};
    tbl[5]  = '{7,  1'b0, 16'h0000, 4'h0, 4'hE, 1'b0, 1'b1};
    tbl[6]  = '{8,  1'b0, 16'h0000, 4'h0, 4'hF, 1'b0, 1'b1};
    tbl[7]  = '{31, 1'b0, 16'h0000, 4'h0, 4'h7, 1'b1, 1'b1};
    tbl[8]  = '{32, 1'b0, 16'h0000, 4'h1, 4'hF, 1'b0, 1'b0};
    tbl[9]  = '{34, 1'b0, 16'h0000, 4'h1, 4'hE, 1'b0, 1'b0};
    tbl[10] = '{39, 1'b0, 16'h0000, 4'h1, 4'hE, 1'b0, 1'b0};
    tbl[11] = '{40, 1'b0, 16'h0000, 4'h2, 4'hF, 1'b0, 1'b0};
    tbl[12] = '{42, 1'b0, 16'h0000, 4'h2, 4'hD, 1'b0, 1'b0};
    tbl[13] = '{50, 1'b0, 16'h0000, 4'h3, 4'hB, 1'b0, 1'b0};
    tbl[14] = '{58, 1'b0, 16'h0000, 4'h4, 4'h7, 1'b0, 1'b0};
    tbl[15] = '{63, 1'b0, 16'h0000, 4'h4, 4'h7, 1'b1, 1'b0};
    tbl[16] = '{64, 1'b0, 16'h0000, 4'h1, 4'hF, 1'b0, 1'b0};

    @(negedge clk);
    do_reset(3);

    // Reset release and double-buffered load, driven from the checkpoint table.
    while (t < 72) begin
      ld = 1'b0;
      d = '0;
      for (int k = 0; k < 17; k++) begin
        if (tbl[k].cyc == t) begin
          check($sformatf("tbl c%0d dig_code", t), dig_code, tbl[k].code);
          check($sformatf("tbl c%0d dig_en", t), dig_en, tbl[k].en);
          check($sformatf("tbl c%0d frame_tick", t), frame_tick, tbl[k].tick);
          check($sformatf("tbl c%0d pending", t), pending, tbl[k].pend);
          ld = tbl[k].ld;
          d = tbl[k].d;
        end
      end
      step(ld, d, 4'b0000);
    end

    // Masking digit 2: code still scans, enable stays off.
    while (t < 128) begin
      if (t >= 112 && t < 120) begin
        check("mask slot2 dig_code", dig_code, 4'h3);
        check("mask slot2 dig_en", dig_en, 4'hF);
      end
      if (t == 106) check("mask slot1 dig_en", dig_en, 4'hD);
      step(1'b0, '0, 4'b0100);
    end

    // Load coinciding with the frame tick goes straight to the display.
    while (t < 159) step(1'b0, '0, 4'b0000);
    check("coinc frame_tick", frame_tick, 1'b1);
    step(1'b1, 16'h9876, 4'b0000);
    check("coinc pending", pending, 1'b0);
    check("coinc slot0 code", dig_code, 4'h6);
    while (t < 168) step(1'b0, '0, 4'b0000);
    check("coinc slot1 code", dig_code, 4'h7);

    // Overwrite within one frame: last load wins, first value never shown.
    do_reset(3);
    saw_one = 1'b0;
    while (t < 96) begin
      if (dig_code == 4'h1) saw_one = 1'b1;
      if (t >= 64) check("ovr dig_code", dig_code, 4'h2);
      step(t == 33 || t == 40, (t == 33) ? 16'h1111 : 16'h2222, 4'b0000);
    end
    check("ovr never shows 1", saw_one, 1'b0);

    // Reset in the middle of slot 1 with data pending.
    do_reset(3);
    while (t < 45) step(t == 3 || t == 40, (t == 3) ? 16'hABCD : 16'h5555, 4'b0000);
    check("midrst pre code", dig_code, 4'hC);
    check("midrst pre pending", pending, 1'b1);
    do_reset(1);
    while (t < 40) begin
      if (t == 2) check("midrst guard end en", dig_en, 4'hE);
      if (t == 10) check("midrst slot1 code", dig_code, 4'h0);
      step(1'b0, '0, 4'b0000);
    end

    // Random loads (some forced onto frame ticks) and mask changes.
    m = 4'b0000;
    for (int i = 0; i < 3000; i++) begin
      ld = ($urandom_range(7) == 0) ||
           ((t % FRAME == FRAME - 1) && ($urandom_range(1) == 1));
      d = 16'($urandom);
      if ($urandom_range(15) == 0) m = 4'($urandom);
      step(ld, d, m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
